// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D SPI responder.
package a2d_pkg;

  localparam int A2D_FRM_BITS = 16;
  localparam int A2D_RES_BITS = 12;
  localparam int CHNL_MSB     = 13;
  localparam int CHNL_LSB     = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } a2d_resp_state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Oversampling synchronizer for SS_n/SCLK/MOSI with edge detection on SS_n and SCLK.
module spi_in_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ss_n,
  input  logic sclk,
  input  logic mosi,
  output logic ss_n_s,
  output logic mosi_s,
  output logic ss_fall,
  output logic ss_rise,
  output logic sclk_fall,
  output logic sclk_rise
);

  // Lane 0 = SS_n, lane 1 = SCLK, lane 2 = MOSI; SS_n and SCLK idle high.
  localparam logic [2:0] LANE_RST = 3'b011;

  logic [2:0] lane_in;
  logic [2:0] lane_s;
  logic       ss_prev_reg;
  logic       sclk_prev_reg;

  assign lane_in = {mosi, sclk, ss_n};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [SYNC_STG-1:0] chain_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain_reg <= {SYNC_STG{LANE_RST[gi]}};
        end else begin
          chain_reg <= {chain_reg[SYNC_STG-2:0], lane_in[gi]};
        end
      end

      assign lane_s[gi] = chain_reg[SYNC_STG-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_prev_reg   <= 1'b1;
      sclk_prev_reg <= 1'b1;
    end else begin
      ss_prev_reg   <= lane_s[0];
      sclk_prev_reg <= lane_s[1];
    end
  end

  assign ss_n_s    = lane_s[0];
  assign mosi_s    = lane_s[2];
  assign ss_fall   = ss_prev_reg & ~lane_s[0];
  assign ss_rise   = ~ss_prev_reg & lane_s[0];
  assign sclk_fall = sclk_prev_reg & ~lane_s[1];
  assign sclk_rise = ~sclk_prev_reg & lane_s[1];

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating an 8-channel 12-bit A2D; returns the previous frame's result.
// Optional short-frame error reporting (frm_err, err_cnt) with A2D_RESP_FRM_ERR_EN.
module a2d_spi_resp
  import a2d_pkg::*;
#(
  parameter int FRM_BITS = A2D_FRM_BITS,
  parameter int RES_BITS = A2D_RES_BITS,
  parameter int SYNC_STG = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                SCLK,
  input  logic                MOSI,
  output logic                MISO,
  input  logic [RES_BITS-1:0] ana_data,
  output logic [2:0]          chnnl,
  output logic [FRM_BITS-1:0] cmd,
  output logic                cmd_vld,
  output logic [RES_BITS-1:0] res_q
`ifdef A2D_RESP_FRM_ERR_EN
  ,
  output logic                frm_err,
  output logic [3:0]          err_cnt
`endif
);

  localparam int                CNT_W    = $clog2(FRM_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRM_BITS);

  a2d_resp_state_t     state_reg;
  a2d_resp_state_t     state_next;
  logic [FRM_BITS-1:0] rx_shft_reg;
  logic [FRM_BITS-1:0] tx_shft_reg;
  logic [CNT_W-1:0]    bit_cnt_reg;
  logic [FRM_BITS-1:0] cmd_reg;
  logic [2:0]          chnnl_reg;
  logic [RES_BITS-1:0] res_q_reg;
  logic                frame_full;

  logic ss_n_s, mosi_s, ss_fall, ss_rise, sclk_fall, sclk_rise;

  spi_in_sync #(
    .SYNC_STG (SYNC_STG)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ss_n      (SS_n),
    .sclk      (SCLK),
    .mosi      (MOSI),
    .ss_n_s    (ss_n_s),
    .mosi_s    (mosi_s),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .sclk_fall (sclk_fall),
    .sclk_rise (sclk_rise)
  );

  assign frame_full = (bit_cnt_reg == CNT_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ss_fall) state_next = SHIFT;
      SHIFT:   if (ss_rise) state_next = frame_full ? LATCH : IDLE;
      LATCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // cmd_vld is asserted in LATCH, the cycle in which cmd/chnnl first show the new frame.
  always_comb begin
    cmd_vld = (state_reg == LATCH);
    MISO    = ~ss_n_s & tx_shft_reg[FRM_BITS-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shft_reg <= '0;
      tx_shft_reg <= '0;
      bit_cnt_reg <= '0;
      cmd_reg     <= '0;
      chnnl_reg   <= '0;
      res_q_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ss_fall) begin
            tx_shft_reg <= {{(FRM_BITS-RES_BITS){1'b0}}, res_q_reg};
            bit_cnt_reg <= '0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_shft_reg <= {rx_shft_reg[FRM_BITS-2:0], mosi_s};
            if (!frame_full) bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          end
          // The leading fall precedes any rise, so skipping it keeps the MSB on MISO.
          if (sclk_fall && (bit_cnt_reg != '0)) begin
            tx_shft_reg <= {tx_shft_reg[FRM_BITS-2:0], 1'b0};
          end
          if (ss_rise && frame_full) begin
            cmd_reg   <= rx_shft_reg;
            chnnl_reg <= rx_shft_reg[CHNL_MSB:CHNL_LSB];
          end
        end
        LATCH: begin
          res_q_reg <= ana_data;
        end
        default: ;
      endcase
    end
  end

  assign cmd   = cmd_reg;
  assign chnnl = chnnl_reg;
  assign res_q = res_q_reg;

`ifdef A2D_RESP_FRM_ERR_EN
  logic       frm_err_reg;
  logic [3:0] err_cnt_reg;
  logic       short_frame;

  assign short_frame = (state_reg == SHIFT) && ss_rise && !frame_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_err_reg <= 1'b0;
      err_cnt_reg <= 4'd0;
    end else begin
      frm_err_reg <= short_frame;
      if (short_frame && (err_cnt_reg != 4'hF)) begin
        err_cnt_reg <= err_cnt_reg + 4'd1;
      end
    end
  end

  assign frm_err = frm_err_reg;
  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Self-checking bench for a2d_spi_resp: directed table, multi-cycle sequences, random frames.
module tb_a2d_spi_resp;

  localparam int H = 5;  // clk cycles per SCLK phase

  typedef struct {
    logic [31:0] bits;
    int          n;
    logic [31:0] exp_rd;
    logic [15:0] exp_cmd;
    logic [2:0]  exp_ch;
    logic [11:0] exp_res;
    int          exp_vld;
    int          exp_err;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n  = 1'b1;
  logic        SCLK  = 1'b1;
  logic        MOSI  = 1'b0;
  logic        MISO;
  logic [11:0] ana_data;
  logic [2:0]  chnnl;
  logic [15:0] cmd;
  logic        cmd_vld;
  logic [11:0] res_q;
`ifdef A2D_RESP_FRM_ERR_EN
  logic        frm_err;
  logic [3:0]  err_cnt;
`endif

  logic [11:0] ana_tbl [8];
  int checks = 0;
  int errors = 0;
  int vld_cycles = 0;
  int err_cycles = 0;

  // Reference model state: what the A2D should hold after each frame.
  logic [11:0] m_res;
  logic [15:0] m_cmd;
  logic [2:0]  m_ch;
  int          m_err;

  always #5 clk = ~clk;

  assign ana_data = ana_tbl[chnnl];

  a2d_spi_resp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .ana_data (ana_data),
    .chnnl    (chnnl),
    .cmd      (cmd),
    .cmd_vld  (cmd_vld),
    .res_q    (res_q)
`ifdef A2D_RESP_FRM_ERR_EN
    ,
    .frm_err  (frm_err),
    .err_cnt  (err_cnt)
`endif
  );

  always @(negedge clk) begin
    if (cmd_vld === 1'b1) vld_cycles++;
`ifdef A2D_RESP_FRM_ERR_EN
    if (frm_err === 1'b1) err_cycles++;
`endif
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Bits the master should see: response word MSB first, zeros once it is exhausted.
  function automatic logic [31:0] exp_rd_f(input logic [11:0] res, input int n);
    logic [15:0] word;
    logic [31:0] r;
    word = {4'b0000, res};
    r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], (i < 16) ? word[15-i] : 1'b0};
    return r;
  endfunction

  task automatic model_reset();
    m_res = '0;
    m_cmd = '0;
    m_ch  = '0;
    m_err = 0;
  endtask

  task automatic model_step(input logic [31:0] bits, input int n,
                            output logic [31:0] exp_rd, output int exp_vld);
    exp_rd = exp_rd_f(m_res, n);
    if (n >= 16) begin
      m_cmd   = bits[15:0];
      m_ch    = m_cmd[13:11];
      m_res   = ana_tbl[m_ch];
      exp_vld = 1;
    end else begin
      if (m_err < 15) m_err++;
      exp_vld = 0;
    end
  endtask

  task automatic sclk_bits(input logic [31:0] bits, input int n, output logic [31:0] rd);
    rd = '0;
    for (int i = n - 1; i >= 0; i--) begin
      SCLK = 1'b0;
      MOSI = bits[i];
      repeat (H) @(posedge clk);
      #1;
      rd   = {rd[30:0], MISO};
      SCLK = 1'b1;
      repeat (H) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_frame(input logic [31:0] bits, input int n, output logic [31:0] rd);
    SS_n = 1'b0;
    repeat (H) @(posedge clk);
    #1;
    sclk_bits(bits, n, rd);
    SS_n = 1'b1;
  endtask

  task automatic frame_and_check(input logic [31:0] bits, input int n, input logic [31:0] exp_rd,
                                 input logic [15:0] exp_cmd, input logic [2:0] exp_ch,
                                 input logic [11:0] exp_res, input int exp_vld, input int exp_err);
    int          v0;
    int          e0;
    logic [31:0] rd;
    v0 = vld_cycles;
    e0 = err_cycles;
    do_frame(bits, n, rd);
    // Synced rise acts on the 3rd edge; res_q follows one edge later.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cmd_vld_pulse", {31'b0, cmd_vld}, exp_vld);
    @(posedge clk);
    @(negedge clk);
    chk("res_q", {20'b0, res_q}, {20'b0, exp_res});
    chk("cmd", {16'b0, cmd}, {16'b0, exp_cmd});
    chk("chnnl", {29'b0, chnnl}, {29'b0, exp_ch});
    chk("miso_idle", {31'b0, MISO}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("miso_read", rd, exp_rd);
    chk("vld_cycles", vld_cycles - v0, exp_vld);
`ifdef A2D_RESP_FRM_ERR_EN
    chk("err_cnt", {28'b0, err_cnt}, exp_err);
    chk("frm_err_cycles", err_cycles - e0, (exp_vld == 0) ? 1 : 0);
`endif
    $display("frame n=%0d bits=%h rd=%h cmd=%h chnnl=%0d res_q=%h", n, bits, rd, cmd, chnnl, res_q);
  endtask

  task automatic model_frame(input logic [31:0] bits, input int n);
    logic [31:0] exp_rd;
    int          exp_vld;
    model_step(bits, n, exp_rd, exp_vld);
    frame_and_check(bits, n, exp_rd, m_cmd, m_ch, m_res, exp_vld, m_err);
  endtask

  initial begin
    vec_t        vecs [4];
    logic [31:0] rd;
    logic [31:0] exp_rd;
    int          exp_vld;
    int          v0;
    int          r;
    int          n;

    ana_tbl[0] = 12'h123; ana_tbl[1] = 12'h3C7; ana_tbl[2] = 12'h2B4; ana_tbl[3] = 12'hA5C;
    ana_tbl[4] = 12'h4E1; ana_tbl[5] = 12'h5F0; ana_tbl[6] = 12'h6D9; ana_tbl[7] = 12'h7E8;

    vecs[0] = '{32'h0000_1800, 16, 32'h0000_0000, 16'h1800, 3'd3, 12'hA5C, 1, 0};
    vecs[1] = '{32'h0000_0800, 16, 32'h0000_0A5C, 16'h0800, 3'd1, 12'h3C7, 1, 0};
    vecs[2] = '{32'h0000_00E0, 10, 32'h0000_000F, 16'h0800, 3'd1, 12'h3C7, 0, 1};
    vecs[3] = '{32'h000F_2800, 20, 32'h0000_3C70, 16'h2800, 3'd5, 12'h5F0, 1, 1};

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rst_miso", {31'b0, MISO}, 32'd0);
    chk("rst_cmd_vld", {31'b0, cmd_vld}, 32'd0);
    chk("rst_res_q", {20'b0, res_q}, 32'd0);
    chk("rst_chnnl", {29'b0, chnnl}, 32'd0);
    chk("rst_cmd", {16'b0, cmd}, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      frame_and_check(vecs[i].bits, vecs[i].n, vecs[i].exp_rd, vecs[i].exp_cmd, vecs[i].exp_ch,
                      vecs[i].exp_res, vecs[i].exp_vld, vecs[i].exp_err);
    end

    // Reset in the middle of a frame
    SS_n = 1'b0;
    repeat (H) @(posedge clk);
    #1;
    sclk_bits(32'h55, 7, rd);
    rst_n = 1'b0;
    #1;
    chk("midrst_miso", {31'b0, MISO}, 32'd0);
    chk("midrst_cmd_vld", {31'b0, cmd_vld}, 32'd0);
    chk("midrst_cmd", {16'b0, cmd}, 32'd0);
    chk("midrst_chnnl", {29'b0, chnnl}, 32'd0);
    chk("midrst_res_q", {20'b0, res_q}, 32'd0);
`ifdef A2D_RESP_FRM_ERR_EN
    chk("midrst_err_cnt", {28'b0, err_cnt}, 32'd0);
`endif
    $display("reset mid-frame after 7 SCLKs");
    SS_n = 1'b1;
    SCLK = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    model_frame(32'h3800, 16);

    // Back-to-back frames with SS_n high for exactly 3 clk
    v0 = vld_cycles;
    for (int k = 0; k < 8; k++) begin
      model_step(32'(k << 11), 16, exp_rd, exp_vld);
      do_frame(32'(k << 11), 16, rd);
      chk("b2b_read", rd, exp_rd);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_cmd", {16'b0, cmd}, {16'b0, m_cmd});
      $display("b2b frame %0d rd=%h cmd=%h", k, rd, cmd);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_vld_cycles", vld_cycles - v0, 8);
    chk("b2b_res_q", {20'b0, res_q}, {20'b0, m_res});
    chk("b2b_chnnl", {29'b0, chnnl}, 32'd7);

    // Randomized frames: mostly full, some short, some over-long
    for (int f = 0; f < 40; f++) begin
      for (int c = 0; c < 8; c++) ana_tbl[c] = 12'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7) n = 16;
      else if (r < 9) n = $urandom_range(1, 15);
      else n = $urandom_range(17, 20);
      model_frame($urandom, n);
    end

    // Enough short frames to saturate the error counter
    for (int f = 0; f < 16; f++) model_frame($urandom, 2);
    model_frame(32'h1000, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
